eep_spi_resp: RTL and testbench

SPI responder (slave end) for the scope's 16-bit SPI bus, emulating the calibration EEPROM on the board. It receives frames from the SPI master, decodes read, write and ID commands against a 64×8 register array, and returns read data on MISO during the following frame. It is used as a synthesizable EEPROM model in full-chip benches and as an SPI-slave building block for board-level emulation.

---
 rtl/eep_pkg.sv | 36 +++
 rtl/spi_sync_edge.sv | 20 ++
 rtl/eep_spi_resp.sv | 156 +++++++++++++++
 tb/tb_eep_spi_resp.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eep_pkg.sv
// eep_pkg: shared types and frame geometry for the EEPROM SPI responder.
// Opcode/state enums, field widths and an opcode decoder.
package eep_pkg;

  typedef enum logic [1:0] {
    OP_RD,
    OP_WR,
    OP_ID
  } eep_op_t;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } eep_state_t;

  localparam int FRAME_W   = 16;
  localparam int OP_W      = 2;
  localparam int ADDR_W    = 6;
  localparam int DATA_W    = 8;
  localparam int CNT_W     = 5;
  localparam int EEP_DEPTH = 64;

  // Opcode field: 00 read, 01 write, 1x ID/NOP.
  function automatic eep_op_t op_decode(input logic [OP_W-1:0] op);
    eep_op_t r;
    r = OP_ID;
    unique case (1'b1)
      op[1]:            r = OP_ID;
      !op[1] && op[0]:  r = OP_WR;
      !op[1] && !op[0]: r = OP_RD;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// spi_sync_edge: three-flop synchronizer for an asynchronous SPI clock.
// Emits single-cycle rise/fall pulses from the last two stages.
module spi_sync_edge (
  input  logic clk,
  input  logic din,
  output logic rise,
  output logic fall
);

  logic [2:0] sr;

  // Shift the async input through three flops.
  always_ff @(posedge clk) begin
    sr <= {sr[1:0], din};
  end

  assign rise = sr[1] & ~sr[2];
  assign fall = ~sr[1] & sr[2];

endmodule

// File: rtl/eep_spi_resp.sv
// eep_spi_resp: SPI mode-0 slave emulating a 64x8 calibration EEPROM.
// Optional EEP_WP_EN adds a write-protect input that rejects writes.
module eep_spi_resp
  import eep_pkg::*;
#(
  parameter int          CLK_PER_SCLK_MIN = 8,
  parameter logic [15:0] ID_WORD          = 16'hA5A5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        SS_n,
  input  logic        SCLK,
  input  logic        MOSI,
  output logic        MISO,
  output logic        frame_done,
  output logic        frame_err,
  output logic [15:0] rx_frame
`ifdef EEP_WP_EN
  ,
  input  logic        wp
`endif
);

  eep_state_t          state, state_n;
  logic [1:0]          ss_sr, mosi_sr;
  logic                ss_s, ss_fall, ss_rise, mosi_s;
  logic                sclk_rise, sclk_fall;
  logic [FRAME_W-1:0]  rx_shift, tx_shift, resp_buf;
  logic [CNT_W-1:0]    bit_cnt;
  logic [DATA_W-1:0]   mem [EEP_DEPTH];
  logic [ADDR_W-1:0]   addr;
  logic [DATA_W-1:0]   data;
  eep_op_t             op;
  logic                frame_ok, do_exec, wp_hit;
  logic [7:0]          hp_cnt;

`ifdef EEP_WP_EN
  assign wp_hit = wp;
`else
  assign wp_hit = 1'b0;
`endif

  spi_sync_edge u_sclk (
    .clk  (clk),
    .din  (SCLK),
    .rise (sclk_rise),
    .fall (sclk_fall)
  );

  // Two-flop synchronizers for slave select and data in.
  always_ff @(posedge clk) begin
    ss_sr   <= {ss_sr[0], SS_n};
    mosi_sr <= {mosi_sr[0], MOSI};
  end

  assign ss_s    = ss_sr[1];
  assign ss_fall = ss_sr[1] & ~ss_sr[0];
  assign ss_rise = ~ss_sr[1] & ss_sr[0];
  assign mosi_s  = mosi_sr[1];

  assign addr     = rx_shift[13:8];
  assign data     = rx_shift[7:0];
  assign op       = op_decode(rx_shift[15:14]);
  assign frame_ok = (bit_cnt == CNT_W'(FRAME_W));
  assign do_exec  = (state == DONE) && frame_ok;

  // Frame state register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Next state and frame status pulses.
  always_comb begin
    state_n    = state;
    frame_done = 1'b0;
    frame_err  = 1'b0;
    unique case (state)
      IDLE:  if (ss_fall) state_n = SHIFT;
      SHIFT: if (ss_rise) state_n = DONE;
      DONE: begin
        state_n    = IDLE;
        frame_done = frame_ok;
        frame_err  = !frame_ok;
      end
      default: state_n = IDLE;
    endcase
  end

  // Shift registers, bit counter, and command response.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_shift <= '0;
      tx_shift <= '0;
      bit_cnt  <= '0;
      rx_frame <= '0;
      resp_buf <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          bit_cnt  <= '0;
          tx_shift <= resp_buf;
        end
        SHIFT: begin
          if (sclk_rise) begin
            rx_shift <= {rx_shift[14:0], mosi_s};
            if (bit_cnt != CNT_W'(FRAME_W + 1))
              bit_cnt <= bit_cnt + CNT_W'(1);
          end
          if (sclk_fall && bit_cnt != '0)
            tx_shift <= {tx_shift[14:0], 1'b0};
        end
        DONE: begin
          if (frame_ok) begin
            rx_frame <= rx_shift;
            case (op)
              OP_RD: resp_buf <= {2'b00, addr, mem[addr]};
              OP_WR: begin
                if (wp_hit)
                  resp_buf <= {2'b11, addr, mem[addr]};
                else
                  resp_buf <= {2'b01, addr, data};
              end
              default: resp_buf <= ID_WORD;
            endcase
          end
        end
        default: bit_cnt <= '0;
      endcase
    end
  end

  // Register array; cleared on reset, written by accepted writes.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < EEP_DEPTH; i++) mem[i] <= '0;
    end else if (do_exec && op == OP_WR && !wp_hit) begin
      mem[addr] <= data;
    end
  end

  assign MISO = (state != IDLE || !ss_s) ? tx_shift[15] : 1'b0;

  // Cycles since the last synchronized SCLK edge, for the rate check.
  always_ff @(posedge clk) begin
    if (rst || sclk_rise || sclk_fall) hp_cnt <= '0;
    else if (hp_cnt != 8'hFF)          hp_cnt <= hp_cnt + 8'd1;
  end

  a_sclk_rate: assert property (
    @(posedge clk) disable iff (rst)
    (state == SHIFT && bit_cnt != '0 && (sclk_rise || sclk_fall))
      |-> (hp_cnt >= 8'(CLK_PER_SCLK_MIN - 1))
  );

endmodule

// File: tb/tb_eep_spi_resp.sv
// tb_eep_spi_resp: SPI master driving the EEPROM responder at clk/16,
// compared against a behavioural EEPROM model kept in this bench.
module tb_eep_spi_resp;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        SS_n = 1'b1;
  logic        SCLK = 1'b0;
  logic        MOSI = 1'b0;
  logic        MISO;
  logic        frame_done;
  logic        frame_err;
  logic [15:0] rx_frame;
  logic        wp_v = 1'b0;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0]  m_mem [64];
  logic [15:0] m_resp;
  logic [15:0] m_rx;

  always #5 clk = ~clk;

  eep_spi_resp #(
    .CLK_PER_SCLK_MIN (8),
    .ID_WORD          (16'hA5A5)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .SS_n       (SS_n),
    .SCLK       (SCLK),
    .MOSI       (MOSI),
    .MISO       (MISO),
    .frame_done (frame_done),
    .frame_err  (frame_err),
    .rx_frame   (rx_frame)
`ifdef EEP_WP_EN
    ,
    .wp         (wp_v)
`endif
  );

  task automatic model_reset();
    for (int i = 0; i < 64; i++) m_mem[i] = 8'h00;
    m_resp = 16'h0000;
    m_rx   = 16'h0000;
  endtask

  // EEPROM behaviour: only exact 16-bit frames take effect.
  task automatic model_frame(input logic [15:0] w, input int n,
                             input logic prot);
    int a;
    if (n != 16) return;
    m_rx = w;
    a = int'(w[13:8]);
    if (w[15]) begin
      m_resp = 16'hA5A5;
    end else if (w[14]) begin
      if (prot) begin
        m_resp = {2'b11, w[13:8], m_mem[a]};
      end else begin
        m_mem[a] = w[7:0];
        m_resp = {2'b01, w[13:8], w[7:0]};
      end
    end else begin
      m_resp = {2'b00, w[13:8], m_mem[a]};
    end
  endtask

  // One master frame: n rises, optional 1-clk reset after bit rst_at.
  task automatic xfer(input logic [15:0] w, input int n, input int rst_at,
                      output logic [15:0] so, output int nd, output int ne);
    so = 16'h0000;
    nd = 0;
    ne = 0;
    @(negedge clk) SS_n = 1'b0;
    repeat (8) @(negedge clk);
    for (int i = 0; i < n; i++) begin
      if (i < 16) MOSI = w[15-i];
      else        MOSI = 1'b0;
      repeat (8) @(negedge clk);
      SCLK = 1'b1;
      so = {so[14:0], MISO};
      repeat (8) @(negedge clk);
      SCLK = 1'b0;
      if (i + 1 == rst_at) begin
        @(negedge clk) rst = 1'b1;
        @(negedge clk) rst = 1'b0;
      end
    end
    repeat (8) @(negedge clk);
    SS_n = 1'b1;
    repeat (12) begin
      @(negedge clk);
      if (frame_done) nd++;
      if (frame_err)  ne++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (5) @(negedge clk);
    model_reset();
    vectors++;
    if (MISO !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_miso got %b want 0", MISO);
    end
    vectors++;
    if (frame_done !== 1'b0 || frame_err !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_pulses got %b%b want 00", frame_done, frame_err);
    end
    rst = 1'b0;
    @(negedge clk);
    vectors++;
    if (rx_frame !== 16'h0000) begin
      miscompares++;
      $display("FAIL reset_rx got %h want 0000", rx_frame);
    end
  endtask

  task automatic test_id();
    logic [15:0] so;
    int nd, ne;
    xfer(16'h8000, 16, -1, so, nd, ne);
    model_frame(16'h8000, 16, 1'b0);
    vectors++;
    if (so !== 16'h0000 || nd != 1 || ne != 0) begin
      miscompares++;
      $display("FAIL id_first got so=%h nd=%0d ne=%0d want 0000/1/0",
               so, nd, ne);
    end
    xfer(16'h0000, 16, -1, so, nd, ne);
    model_frame(16'h0000, 16, 1'b0);
    vectors++;
    if (so !== 16'hA5A5 || nd != 1) begin
      miscompares++;
      $display("FAIL id_word got so=%h nd=%0d want a5a5/1", so, nd);
    end
    vectors++;
    if (rx_frame !== m_rx) begin
      miscompares++;
      $display("FAIL id_rx got %h want %h", rx_frame, m_rx);
    end
  endtask

  task automatic test_write_read();
    logic [15:0] so;
    int nd, ne;
    xfer(16'h4A3C, 16, -1, so, nd, ne);
    model_frame(16'h4A3C, 16, 1'b0);
    xfer(16'h0A00, 16, -1, so, nd, ne);
    model_frame(16'h0A00, 16, 1'b0);
    vectors++;
    if (so !== 16'h4A3C) begin
      miscompares++;
      $display("FAIL wr_resp got %h want 4a3c", so);
    end
    xfer(16'h8000, 16, -1, so, nd, ne);
    model_frame(16'h8000, 16, 1'b0);
    vectors++;
    if (so !== 16'h0A3C || nd != 1 || ne != 0) begin
      miscompares++;
      $display("FAIL rd_resp got %h nd=%0d ne=%0d want 0a3c/1/0",
               so, nd, ne);
    end
  endtask

  task automatic test_bad_frames();
    logic [15:0] so;
    logic [15:0] exp;
    int nd, ne;
    int lens [3] = '{12, 17, 0};
    foreach (lens[k]) begin
      xfer(16'h4A77, lens[k], -1, so, nd, ne);
      model_frame(16'h4A77, lens[k], 1'b0);
      vectors++;
      if (ne != 1 || nd != 0) begin
        miscompares++;
        $display("FAIL bad_len%0d got nd=%0d ne=%0d want 0/1",
                 lens[k], nd, ne);
      end
      vectors++;
      if (rx_frame !== m_rx) begin
        miscompares++;
        $display("FAIL bad_rx%0d got %h want %h", lens[k], rx_frame, m_rx);
      end
    end
    exp = m_resp;
    xfer(16'h0A00, 16, -1, so, nd, ne);
    model_frame(16'h0A00, 16, 1'b0);
    vectors++;
    if (so !== exp) begin
      miscompares++;
      $display("FAIL bad_resp_kept got %h want %h", so, exp);
    end
    xfer(16'h8000, 16, -1, so, nd, ne);
    model_frame(16'h8000, 16, 1'b0);
    vectors++;
    if (so !== 16'h0A3C) begin
      miscompares++;
      $display("FAIL bad_mem_kept got %h want 0a3c", so);
    end
  endtask

  task automatic test_reset_mid();
    logic [15:0] so;
    int nd, ne;
    xfer(16'h4555, 16, -1, so, nd, ne);
    model_frame(16'h4555, 16, 1'b0);
    xfer(16'h0500, 16, 7, so, nd, ne);
    model_reset();
    vectors++;
    if (nd != 0 || ne != 0 || rx_frame !== 16'h0000) begin
      miscompares++;
      $display("FAIL mid_rst got nd=%0d ne=%0d rx=%h want 0/0/0000",
               nd, ne, rx_frame);
    end
    xfer(16'h0500, 16, -1, so, nd, ne);
    model_frame(16'h0500, 16, 1'b0);
    vectors++;
    if (so !== 16'h0000 || nd != 1) begin
      miscompares++;
      $display("FAIL mid_first got %h nd=%0d want 0000/1", so, nd);
    end
    xfer(16'h8000, 16, -1, so, nd, ne);
    model_frame(16'h8000, 16, 1'b0);
    vectors++;
    if (so !== 16'h0500) begin
      miscompares++;
      $display("FAIL mid_read got %h want 0500", so);
    end
  endtask

`ifdef EEP_WP_EN
  task automatic test_wp();
    logic [15:0] so;
    int nd, ne;
    wp_v = 1'b1;
    xfer(16'h7FFF, 16, -1, so, nd, ne);
    model_frame(16'h7FFF, 16, 1'b1);
    wp_v = 1'b0;
    vectors++;
    if (nd != 1) begin
      miscompares++;
      $display("FAIL wp_done got %0d want 1", nd);
    end
    xfer(16'h3F00, 16, -1, so, nd, ne);
    model_frame(16'h3F00, 16, 1'b0);
    vectors++;
    if (so !== 16'hFF00) begin
      miscompares++;
      $display("FAIL wp_resp got %h want ff00", so);
    end
    xfer(16'h8000, 16, -1, so, nd, ne);
    model_frame(16'h8000, 16, 1'b0);
    vectors++;
    if (so !== 16'h3F00) begin
      miscompares++;
      $display("FAIL wp_mem got %h want 3f00", so);
    end
  endtask
`endif

  task automatic test_random();
    logic [15:0] so;
    logic [15:0] exp;
    logic [15:0] w;
    logic [5:0]  a;
    int nd, ne;
    for (int p = 0; p < 20; p++) begin
      a = 6'($urandom_range(0, 63));
      for (int j = 0; j < 2; j++) begin
        if (j == 0) w = {2'b01, a, 8'($urandom)};
        else        w = {2'b00, a, 8'($urandom)};
        exp = m_resp;
        xfer(w, 16, -1, so, nd, ne);
        model_frame(w, 16, 1'b0);
        vectors++;
        if (so !== exp || nd != 1 || ne != 0) begin
          miscompares++;
          $display("FAIL rnd%0d_%0d got %h nd=%0d ne=%0d want %h/1/0",
                   p, j, so, nd, ne, exp);
        end
      end
    end
    exp = m_resp;
    xfer(16'hC000, 16, -1, so, nd, ne);
    model_frame(16'hC000, 16, 1'b0);
    vectors++;
    if (so !== exp || rx_frame !== m_rx) begin
      miscompares++;
      $display("FAIL rnd_last got %h rx=%h want %h rx=%h",
               so, rx_frame, exp, m_rx);
    end
  endtask

  initial begin
    test_reset();
    test_id();
    test_write_read();
    test_bad_frames();
    test_reset_mid();
`ifdef EEP_WP_EN
    test_wp();
`endif
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
